// File: rtl/regfile_scoreboard.sv
// Parametrised integer register file with two combinational read ports, one
// synchronous write port, optional same-cycle write->read forwarding, and a
// per-register pending-write scoreboard used by decode to stall on hazards.
// x0 always reads zero; reset restores x0=0 and reg[SP_INDEX]=SP_INIT.
module regfile_scoreboard #(
   parameter int unsigned            DATA_WIDTH = 32,
   parameter int unsigned            ADDR_WIDTH = 5,
   parameter int unsigned            SP_INDEX   = 2,
   parameter logic [DATA_WIDTH-1:0]  SP_INIT    = DATA_WIDTH'(32'h0110_0000),
   parameter bit                     BYPASS     = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  wb_enable,
   input  logic [ADDR_WIDTH-1:0] wb_addr,
   input  logic [DATA_WIDTH-1:0] wb_data,
   input  logic [ADDR_WIDTH-1:0] rs1_addr,
   input  logic [ADDR_WIDTH-1:0] rs2_addr,
   output logic [DATA_WIDTH-1:0] rs1_data,
   output logic [DATA_WIDTH-1:0] rs2_data,
   input  logic                  issue_valid,
   input  logic [ADDR_WIDTH-1:0] issue_rd,
   input  logic                  flush,
   output logic                  rs1_busy,
   output logic                  rs2_busy
);

   localparam int unsigned NREGS = 2 ** ADDR_WIDTH;

   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
   localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};

   // Architectural register state and its next-state image.
   logic [DATA_WIDTH-1:0] regs_q [NREGS];
   logic [DATA_WIDTH-1:0] regs_d [NREGS];

   // One pending bit per register; bit 0 is held at zero.
   logic [NREGS-1:0] pending_q;
   logic [NREGS-1:0] pending_d;

   // Qualified strobes: anything targeting x0 is a no-op.
   logic wb_we_s;
   logic issue_set_s;
   logic rs1_fwd_s;
   logic rs2_fwd_s;

   // Decode the write and issue strobes and the forwarding hits.
   always_comb begin
      wb_we_s     = wb_enable && (wb_addr != ZERO_ADDR);
      issue_set_s = issue_valid && (issue_rd != ZERO_ADDR);
      if (BYPASS != 1'b0) begin
         rs1_fwd_s = wb_we_s && (wb_addr == rs1_addr);
         rs2_fwd_s = wb_we_s && (wb_addr == rs2_addr);
      end else begin
         rs1_fwd_s = 1'b0;
         rs2_fwd_s = 1'b0;
      end
   end

   // Next-state for the register array: only the addressed non-zero entry changes.
   always_comb begin
      for (int i = 0; i < int'(NREGS); i++) begin
         if (wb_we_s && (wb_addr == ADDR_WIDTH'(i))) begin
            regs_d[i] = wb_data;
         end else begin
            regs_d[i] = regs_q[i];
         end
      end
   end

   // Register array state; reset discards any write presented on the same edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            if (i == int'(SP_INDEX)) begin
               regs_q[i] <= SP_INIT;
            end else begin
               regs_q[i] <= ZERO_DATA;
            end
         end
      end else begin
         for (int i = 0; i < int'(NREGS); i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Scoreboard next-state: flush beats issue, issue (younger producer) beats writeback clear.
   always_comb begin
      pending_d = pending_q;
      for (int i = 0; i < int'(NREGS); i++) begin
         if (flush) begin
            pending_d[i] = 1'b0;
         end else if (issue_set_s && (issue_rd == ADDR_WIDTH'(i))) begin
            pending_d[i] = 1'b1;
         end else if (wb_we_s && (wb_addr == ADDR_WIDTH'(i))) begin
            pending_d[i] = 1'b0;
         end else begin
            pending_d[i] = pending_q[i];
         end
      end
      pending_d[0] = 1'b0;
   end

   // Scoreboard state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pending_q <= {NREGS{1'b0}};
      end else begin
         pending_q <= pending_d;
      end
   end

   // Read port 1: x0 reads zero, forwarded writeback next, else stored value.
   always_comb begin
      rs1_data = ZERO_DATA;
      if (rs1_addr == ZERO_ADDR) begin
         rs1_data = ZERO_DATA;
      end else if (rs1_fwd_s) begin
         rs1_data = wb_data;
      end else begin
         rs1_data = regs_q[rs1_addr];
      end
   end

   // Read port 2: same selection as port 1.
   always_comb begin
      rs2_data = ZERO_DATA;
      if (rs2_addr == ZERO_ADDR) begin
         rs2_data = ZERO_DATA;
      end else if (rs2_fwd_s) begin
         rs2_data = wb_data;
      end else begin
         rs2_data = regs_q[rs2_addr];
      end
   end

   // Busy 1: a forwarded writeback satisfies the consumer, so it does not stall.
   always_comb begin
      rs1_busy = 1'b0;
      if (rs1_addr == ZERO_ADDR) begin
         rs1_busy = 1'b0;
      end else if (rs1_fwd_s) begin
         rs1_busy = 1'b0;
      end else begin
         rs1_busy = pending_q[rs1_addr];
      end
   end

   // Busy 2: same masking as port 1.
   always_comb begin
      rs2_busy = 1'b0;
      if (rs2_addr == ZERO_ADDR) begin
         rs2_busy = 1'b0;
      end else if (rs2_fwd_s) begin
         rs2_busy = 1'b0;
      end else begin
         rs2_busy = pending_q[rs2_addr];
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: two instances share one stimulus stream.
//  dut_a: defaults (32-bit data, 32 regs, forwarding on)
//  dut_b: 64-bit data, 16 regs, forwarding off
// Expected responses come from a behavioural model, are queued by the driver,
// and are popped and compared by an independent monitor on the falling edge.
module tb_regfile_scoreboard;

   localparam logic [63:0] SP_INIT_V = 64'h0000_0000_0110_0000;

   logic        clock = 1'b0;
   logic        reset;
   logic        wb_enable;
   logic [4:0]  wb_addr;
   logic [63:0] wb_data;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        flush;

   logic [31:0] a_rs1_data, a_rs2_data;
   logic        a_rs1_busy, a_rs2_busy;
   logic [63:0] b_rs1_data, b_rs2_data;
   logic        b_rs1_busy, b_rs2_busy;

   always #5 clock = ~clock;

   regfile_scoreboard dut_a (
      .clock       (clock),
      .reset       (reset),
      .wb_enable   (wb_enable),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data[31:0]),
      .rs1_addr    (rs1_addr),
      .rs2_addr    (rs2_addr),
      .rs1_data    (a_rs1_data),
      .rs2_data    (a_rs2_data),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .flush       (flush),
      .rs1_busy    (a_rs1_busy),
      .rs2_busy    (a_rs2_busy)
   );

   regfile_scoreboard #(
      .DATA_WIDTH (64),
      .ADDR_WIDTH (4),
      .SP_INDEX   (2),
      .BYPASS     (1'b0)
   ) dut_b (
      .clock       (clock),
      .reset       (reset),
      .wb_enable   (wb_enable),
      .wb_addr     (wb_addr[3:0]),
      .wb_data     (wb_data),
      .rs1_addr    (rs1_addr[3:0]),
      .rs2_addr    (rs2_addr[3:0]),
      .rs1_data    (b_rs1_data),
      .rs2_data    (b_rs2_data),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd[3:0]),
      .flush       (flush),
      .rs1_busy    (b_rs1_busy),
      .rs2_busy    (b_rs2_busy)
   );

   typedef struct {
      int          k;
      logic [63:0] d1;
      logic [63:0] d2;
      logic        b1;
      logic        b2;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: register contents and pending flags per instance.
   logic [63:0] m_reg  [2][32];
   bit          m_pend [2][32];

   function automatic logic [4:0] amask(int k, logic [4:0] a);
      return (k == 0) ? a : {1'b0, a[3:0]};
   endfunction

   function automatic logic [63:0] dmask(int k, logic [63:0] d);
      return (k == 0) ? {32'h0, d[31:0]} : d;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 32; i++) begin
            m_reg[k][i]  = (i == 2) ? SP_INIT_V : 64'h0;
            m_pend[k][i] = 1'b0;
         end
      end
   endtask

   // Expected combinational outputs for the inputs currently applied.
   function automatic exp_t predict(int k);
      exp_t        e;
      logic [4:0]  wa = amask(k, wb_addr);
      logic [4:0]  r1 = amask(k, rs1_addr);
      logic [4:0]  r2 = amask(k, rs2_addr);
      bit          fwd = (k == 0) && wb_enable && (wa != 5'd0);
      e.k  = k;
      e.d1 = (r1 == 5'd0) ? 64'h0 : (fwd && wa == r1) ? dmask(k, wb_data) : m_reg[k][r1];
      e.d2 = (r2 == 5'd0) ? 64'h0 : (fwd && wa == r2) ? dmask(k, wb_data) : m_reg[k][r2];
      e.b1 = (r1 != 5'd0) && m_pend[k][r1] && !(fwd && wa == r1);
      e.b2 = (r2 != 5'd0) && m_pend[k][r2] && !(fwd && wa == r2);
      return e;
   endfunction

   // Apply one clock edge to the model using the inputs seen at that edge.
   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         logic [4:0] wa = amask(k, wb_addr);
         logic [4:0] rd = amask(k, issue_rd);
         if (wb_enable && wa != 5'd0) m_reg[k][wa] = dmask(k, wb_data);
         if (flush) begin
            for (int i = 0; i < 32; i++) m_pend[k][i] = 1'b0;
         end else begin
            if (wb_enable && wa != 5'd0) m_pend[k][wa] = 1'b0;
            if (issue_valid && rd != 5'd0) m_pend[k][rd] = 1'b1;
         end
      end
   endtask

   // Drive one cycle of stimulus, queue expectations, advance past the edge.
   task automatic step(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic iv, input logic [4:0] rd, input logic fl);
      wb_enable   = we;
      wb_addr     = wa;
      wb_data     = wd;
      rs1_addr    = r1;
      rs2_addr    = r2;
      issue_valid = iv;
      issue_rd    = rd;
      flush       = fl;
      exp_q.push_back(predict(0));
      exp_q.push_back(predict(1));
      @(posedge clock);
      model_edge();
      #1;
   endtask

   task automatic rd2(input logic [4:0] r1, input logic [4:0] r2);
      step(1'b0, 5'd0, 64'h0, r1, r2, 1'b0, 5'd0, 1'b0);
   endtask

   // Reset asserted mid-cycle while a write and an issue are presented.
   task automatic reset_mid_write(input logic [4:0] wa, input logic [63:0] wd);
      wb_enable   = 1'b1;
      wb_addr     = wa;
      wb_data     = wd;
      issue_valid = 1'b1;
      issue_rd    = wa;
      flush       = 1'b0;
      #2 reset = 1'b1;
      model_reset();
      @(posedge clock);
      #1;
      wb_enable   = 1'b0;
      issue_valid = 1'b0;
      #1 reset = 1'b0;
   endtask

   function automatic logic [4:0] rand_addr();
      return ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
   endfunction

   task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d @%0t: got %h expected %h", name, k, $time, act, exp);
      end
   endtask

   // Monitor: pop every queued expectation and compare against the DUT outputs.
   always @(negedge clock) begin
      while (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         if (mon_e.k == 0) begin
            check("rs1_data", 0, {32'h0, a_rs1_data}, mon_e.d1);
            check("rs2_data", 0, {32'h0, a_rs2_data}, mon_e.d2);
            check("rs1_busy", 0, {63'h0, a_rs1_busy}, {63'h0, mon_e.b1});
            check("rs2_busy", 0, {63'h0, a_rs2_busy}, {63'h0, mon_e.b2});
         end else begin
            check("rs1_data", 1, b_rs1_data, mon_e.d1);
            check("rs2_data", 1, b_rs2_data, mon_e.d2);
            check("rs1_busy", 1, {63'h0, b_rs1_busy}, {63'h0, mon_e.b1});
            check("rs2_busy", 1, {63'h0, b_rs2_busy}, {63'h0, mon_e.b2});
         end
      end
   end

   // Guard against a stuck run.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b1;
      wb_enable   = 1'b0;
      wb_addr     = 5'd0;
      wb_data     = 64'h0;
      rs1_addr    = 5'd0;
      rs2_addr    = 5'd0;
      issue_valid = 1'b0;
      issue_rd    = 5'd0;
      flush       = 1'b0;
      model_reset();
      @(posedge clock);
      #1;
      #1 reset = 1'b0;

      // Reset values
      rd2(5'd0, 5'd2);
      rd2(5'd31, 5'd2);

      // Write/read and x0 write drop
      step(1'b1, 5'd5, 64'h0000_0000_DEAD_BEEF, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
      rd2(5'd5, 5'd0);
      step(1'b1, 5'd0, 64'h0000_0000_0000_1234, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
      rd2(5'd0, 5'd0);

      // Forwarding with a pending producer on x7
      step(1'b0, 5'd0, 64'h0, 5'd0, 5'd0, 1'b1, 5'd7, 1'b0);
      step(1'b1, 5'd7, 64'h1111_2222_A5A5_A5A5, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0);
      rd2(5'd7, 5'd7);

      // Scoreboard set, clear, and same-cycle set-wins
      step(1'b0, 5'd0, 64'h0, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0);
      rd2(5'd0, 5'd9);
      step(1'b1, 5'd9, 64'h0000_0000_0000_0099, 5'd0, 5'd9, 1'b0, 5'd0, 1'b0);
      rd2(5'd9, 5'd9);
      step(1'b1, 5'd9, 64'h0000_0000_0000_0999, 5'd0, 5'd9, 1'b1, 5'd9, 1'b0);
      rd2(5'd9, 5'd9);
      step(1'b1, 5'd9, 64'h0000_0000_0000_9999, 5'd0, 5'd9, 1'b0, 5'd0, 1'b0);
      rd2(5'd9, 5'd9);

      // Flush with a simultaneous writeback and issue
      step(1'b0, 5'd0, 64'h0, 5'd3, 5'd4, 1'b1, 5'd3, 1'b0);
      step(1'b0, 5'd0, 64'h0, 5'd3, 5'd4, 1'b1, 5'd4, 1'b0);
      step(1'b0, 5'd0, 64'h0, 5'd3, 5'd4, 1'b1, 5'd5, 1'b0);
      step(1'b1, 5'd4, 64'h0000_0000_0000_0007, 5'd3, 5'd5, 1'b1, 5'd6, 1'b1);
      rd2(5'd5, 5'd4);
      rd2(5'd3, 5'd6);

      // Reset in the middle of a write discards it
      reset_mid_write(5'd6, 64'hCAFE_F00D_1357_2468);
      rd2(5'd6, 5'd2);
      rd2(5'd5, 5'd31);

      // Top register and full-width data
      step(1'b1, 5'd15, 64'hFEDC_BA98_7654_3210, 5'd15, 5'd2, 1'b0, 5'd0, 1'b0);
      rd2(5'd15, 5'd15);
      step(1'b1, 5'd31, 64'h8000_0001_8000_0001, 5'd31, 5'd15, 1'b1, 5'd31, 1'b0);
      rd2(5'd31, 5'd15);

      // Randomized traffic
      for (int n = 0; n < 800; n++) begin
         step(1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom},
              rand_addr(), rand_addr(),
              1'($urandom_range(0, 1)), rand_addr(),
              ($urandom_range(0, 15) == 0));
      end

      @(negedge clock);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
